wgt_tile_streamer: RTL and testbench

- Synthesizable weight feeder that replaces the behavioural per-layer weight counters.
- Streams TILING weight lanes per beat from an external synchronous weight memory to one conv or FC engine.
- Each job is configured with a base address, a beat count, a count of valid lanes in the final beat, and a repeat-pass count.
- One instance serves one layer port (conv with TILING=1, FC1/FC2 with TILING=8, FC3 with TILING=10).

---
 rtl/wgt_tile_streamer_if.sv | 14 +
 rtl/wgt_tile_streamer.sv | 138 +++++++++++++
 tb/tb_wgt_tile_streamer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wgt_tile_streamer_if.sv
// Weight-memory read port: the streamer drives enable and beat address, and the
// memory returns one full beat of lanes one cycle after the enable.
interface wgt_tile_streamer_if #(
    parameter int WEIGHT_WIDTH = 13,
    parameter int TILING       = 8,
    parameter int ADDR_WIDTH   = 20
);
    logic                           mem_en;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [TILING*WEIGHT_WIDTH-1:0] mem_rdata;

    modport master (output mem_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/wgt_tile_streamer.sv
// Weight feeder: streams TILING-lane beats from a synchronous weight memory to a
// single layer engine, running a block of beats for a configurable number of passes.
module wgt_tile_streamer #(
    parameter int WEIGHT_WIDTH = 13,
    parameter int TILING       = 8,
    parameter int ADDR_WIDTH   = 20,
    parameter int PASS_WIDTH   = 12,
    parameter int LANE_W       = $clog2(TILING) + 1
) (
    input  logic                           clk1,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          cfg_base,
    input  logic [ADDR_WIDTH-1:0]          cfg_beats,
    input  logic [LANE_W-1:0]              cfg_last_lanes,
    input  logic [PASS_WIDTH-1:0]          cfg_passes,
    input  logic                           wgt_read,
    wgt_tile_streamer_if.master            mem,
    output logic [TILING*WEIGHT_WIDTH-1:0] wgt_out,
    output logic                           wgt_valid,
    output logic                           pass_done,
    output logic                           done,
    output logic                           busy,
    output logic                           err
);
    localparam int DW = TILING * WEIGHT_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_beats;
    logic [LANE_W-1:0]     r_last_lanes;
    logic [PASS_WIDTH-1:0] r_passes;
    logic [ADDR_WIDTH-1:0] r_beat_cnt;
    logic [PASS_WIDTH-1:0] r_pass_cnt;
    logic                  r_vld_p1;
    logic                  r_last_p1;
    logic                  r_done_p1;
    logic                  r_err;

    logic w_read_ok;
    logic w_last_beat;
    logic w_last_pass;
    logic w_cfg_ok;

    // Out-of-range lane counts mean "whole beat".
    function automatic logic [LANE_W-1:0] norm_lanes(input logic [LANE_W-1:0] l);
        if (l == '0 || int'(l) > TILING)
            return LANE_W'(TILING);
        return l;
    endfunction

    function automatic logic [DW-1:0] mask_lanes(input logic [DW-1:0] d,
                                                 input logic [LANE_W-1:0] n);
        logic [DW-1:0] m;
        m = d;
        for (int i = 0; i < TILING; i++)
            if (i >= int'(n))
                m[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = '0;
        return m;
    endfunction

    assign w_read_ok   = wgt_read && (r_state == RUN);
    assign w_last_beat = (r_beat_cnt == r_beats - ADDR_WIDTH'(1));
    assign w_last_pass = (r_pass_cnt == r_passes - PASS_WIDTH'(1));
    assign w_cfg_ok    = (cfg_beats != '0) && (cfg_passes != '0);

    assign mem.mem_en   = w_read_ok;
    assign mem.mem_addr = r_base + r_beat_cnt;

    // Stage p1: memory data lands alongside the registered valid/last flags.
    assign wgt_out   = !r_vld_p1  ? '0 :
                       r_last_p1  ? mask_lanes(mem.mem_rdata, r_last_lanes) :
                                    mem.mem_rdata;
    assign wgt_valid = r_vld_p1;
    assign pass_done = r_last_p1;
    assign done      = r_done_p1;
    assign busy      = (r_state == RUN);
    assign err       = r_err;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_beats      <= '0;
            r_last_lanes <= '0;
            r_passes     <= '0;
            r_beat_cnt   <= '0;
            r_pass_cnt   <= '0;
            r_vld_p1     <= 1'b0;
            r_last_p1    <= 1'b0;
            r_done_p1    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_vld_p1  <= w_read_ok;
            r_last_p1 <= w_read_ok && w_last_beat;
            // An empty job still answers with a done pulse so the consumer never stalls.
            r_done_p1 <= (w_read_ok && w_last_beat && w_last_pass) ||
                         ((r_state == IDLE) && start && !w_cfg_ok);

            if (r_state == IDLE && start)
                r_err <= 1'b0;
            else if (r_state == IDLE && wgt_read)
                r_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (start && w_cfg_ok) begin
                        r_base       <= cfg_base;
                        r_beats      <= cfg_beats;
                        r_last_lanes <= norm_lanes(cfg_last_lanes);
                        r_passes     <= cfg_passes;
                        r_beat_cnt   <= '0;
                        r_pass_cnt   <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_read_ok) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (w_last_pass) begin
                                r_pass_cnt <= '0;
                                r_state    <= IDLE;
                            end else begin
                                r_pass_cnt <= r_pass_cnt + PASS_WIDTH'(1);
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wgt_tile_streamer.sv
// Scoreboard bench for wgt_tile_streamer: the driver queues each expected beat as it
// is requested and an independent monitor checks every valid beat the DUT presents.
module tb_wgt_tile_streamer;
    localparam int WW = 13;
    localparam int T  = 10;
    localparam int AW = 12;
    localparam int PW = 12;
    localparam int LW = $clog2(T) + 1;
    localparam int DW = T * WW;

    typedef struct {
        logic [DW-1:0] data;
        logic          pd;
        logic          dn;
    } exp_t;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_beats;
    logic [LW-1:0] cfg_last_lanes;
    logic [PW-1:0] cfg_passes;
    logic          wgt_read;
    logic [DW-1:0] wgt_out;
    logic          wgt_valid, pass_done, done, busy, err;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic deg_ok = 1'b0;

    always #5 clk1 = ~clk1;

    wgt_tile_streamer_if #(.WEIGHT_WIDTH(WW), .TILING(T), .ADDR_WIDTH(AW)) mif ();

    wgt_tile_streamer #(
        .WEIGHT_WIDTH(WW), .TILING(T), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start),
        .cfg_base(cfg_base), .cfg_beats(cfg_beats),
        .cfg_last_lanes(cfg_last_lanes), .cfg_passes(cfg_passes),
        .wgt_read(wgt_read), .mem(mif),
        .wgt_out(wgt_out), .wgt_valid(wgt_valid), .pass_done(pass_done),
        .done(done), .busy(busy), .err(err)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < T; i++)
            w[i*WW +: WW] = WW'(int'(a) * 7 + i * 409 + 1);
        return w;
    endfunction

    // Synchronous weight memory: data one cycle after the enable.
    always @(posedge clk1)
        if (mif.mem_en) mif.mem_rdata <= mem_word(mif.mem_addr);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk1);
            if (wgt_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("wgt_out", wgt_out, e.data);
                    chk("pass_done", pass_done, e.pd);
                    chk("done", done, e.dn);
                end
            end else if ((done || pass_done) && !deg_ok) begin
                chk("stray_done", {done, pass_done}, 0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic start_job(input int b, input int n, input int l, input int p);
        start          = 1'b1;
        cfg_base       = AW'(b);
        cfg_beats      = AW'(n);
        cfg_last_lanes = LW'(l);
        cfg_passes     = PW'(p);
        tick();
        start = 1'b0;
    endtask

    task automatic read_beat(input int b, input int n, input int l, input int beat, input logic last_pass);
        exp_t e;
        logic [AW-1:0] a;
        int le;
        le = (l == 0 || l > T) ? T : l;
        a  = AW'(b + beat);
        e.data = mem_word(a);
        e.pd   = (beat == n - 1);
        e.dn   = e.pd && last_pass;
        if (e.pd)
            for (int i = le; i < T; i++) e.data[i*WW +: WW] = '0;
        wgt_read = 1'b1;
        #1;
        chk("mem_en", mif.mem_en, 1);
        chk("mem_addr", mif.mem_addr, a);
        q.push_back(e);
        tick();
        wgt_read = 1'b0;
    endtask

    // Ends in the done cycle so a following job can start there.
    task automatic run_job(input int b, input int n, input int l, input int p,
                           input logic gap, input logic poke);
        start_job(b, n, l, p);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        for (int ps = 0; ps < p; ps++)
            for (int bt = 0; bt < n; bt++) begin
                read_beat(b, n, l, bt, ps == p - 1);
                if (ps == p - 1 && bt == n - 1) begin
                    chk("busy_drop_with_done", busy, 0);
                end else if (gap) begin
                    if (poke) begin
                        start = 1'b1; cfg_base = 12'h7A5; cfg_beats = 12'd1;
                        cfg_last_lanes = 1; cfg_passes = 12'd1;
                    end
                    #1;
                    chk("mem_en_gap", mif.mem_en, 0);
                    tick();
                    start = 1'b0;
                end
            end
    endtask

    initial begin : driver
        rst_n = 1'b0; start = 1'b0; wgt_read = 1'b0;
        cfg_base = '0; cfg_beats = '0; cfg_last_lanes = '0; cfg_passes = '0;
        #1;
        chk("rst_wgt_valid", wgt_valid, 0);
        chk("rst_wgt_out", wgt_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_en", mif.mem_en, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_done", {done, pass_done}, 0);

        // Read while idle: no memory access, sticky error.
        wgt_read = 1'b1;
        #1;
        chk("idle_mem_en", mif.mem_en, 0);
        tick();
        wgt_read = 1'b0;
        chk("idle_err_set", err, 1);
        chk("idle_no_valid", wgt_valid, 0);
        tick();
        chk("err_sticky", err, 1);

        run_job(5, 1, 10, 1, 1'b0, 1'b0);
        // Back-to-back jobs: each new start lands in the previous done cycle.
        run_job(12'h100, 4, 10, 1, 1'b0, 1'b0);
        run_job(0, 52, 2, 1, 1'b0, 1'b0);
        tick();
        run_job(12'h020, 3, 7, 3, 1'b1, 1'b1);
        tick();
        run_job(12'hFFE, 4, 0, 1, 1'b0, 1'b0);
        tick();
        run_job(12'h055, 2, 15, 1, 1'b0, 1'b0);
        tick(); tick();

        // Degenerate jobs answer with done only.
        deg_ok = 1'b1;
        start_job(12'h010, 5, 3, 0);
        #1;
        chk("deg_pass0_done", done, 1);
        chk("deg_pass0_busy", busy, 0);
        chk("deg_pass0_mem_en", mif.mem_en, 0);
        tick();
        chk("deg_done_pulse", done, 0);
        start_job(12'h010, 0, 3, 2);
        chk("deg_beat0_done", done, 1);
        chk("deg_beat0_busy", busy, 0);
        tick();
        deg_ok = 1'b0;
        chk("deg_no_valid", wgt_valid, 0);

        // Abort after two beats of eight.
        start_job(12'h040, 8, 10, 1);
        read_beat(12'h040, 8, 10, 0, 1'b1);
        read_beat(12'h040, 8, 10, 1, 1'b1);
        tick();
        wgt_read = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("abort_mem_en", mif.mem_en, 0);
        chk("abort_mem_addr", mif.mem_addr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", wgt_valid, 0);
        chk("abort_out", wgt_out, 0);
        tick();
        wgt_read = 1'b0;
        chk("abort_no_done", done, 0);
        chk("abort_no_valid", wgt_valid, 0);
        rst_n = 1'b1;
        tick();
        run_job(12'h300, 2, 5, 1, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
